// File: rtl/addr4u_tr_checker.sv
// Time-redundant checker around an external 4-bit adder: evaluates (A,B), then
// (B,A), and on disagreement a third (A,B) sample that breaks the tie by vote.
module addr4u_tr_checker #(
  parameter int CNT_W    = 8,
  parameter int RETRY_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  input  logic [4:0]       add_s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_sum,
  output logic             out_fault,
  output logic             out_uncorr,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] fault_cnt,
  output logic [CNT_W-1:0] uncorr_cnt,
  output logic [2:0]       o_dbg_state,
  output logic [14:0]      o_dbg_samples
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; valid holds its payload stable until that edge.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EVAL1 = 3'd1,
    S_EVAL2 = 3'd2,
    S_EVAL3 = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // 31 can never be a legal 4-bit + 4-bit sum, so it never wins a vote.
  localparam logic [4:0]       ILLEGAL = 5'd31;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [3:0]       r_op_a;
  logic [3:0]       r_op_b;
  logic [4:0]       r_s1;
  logic [4:0]       r_s2;
  logic [4:0]       r_s3;
  logic [4:0]       r_sum;
  logic             r_fault;
  logic             r_uncorr;
  logic [CNT_W-1:0] r_fault_cnt;
  logic [CNT_W-1:0] r_uncorr_cnt;

  logic w_s1_ok;
  logic w_add_ok;
  logic w_hs;

  assign w_s1_ok  = (r_s1 != ILLEGAL);
  assign w_add_ok = (add_s != ILLEGAL);
  assign w_hs     = (r_state == S_DONE) && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_op_a   <= 4'd0;
      r_op_b   <= 4'd0;
      r_s1     <= 5'd0;
      r_s2     <= 5'd0;
      r_s3     <= 5'd0;
      r_sum    <= 5'd0;
      r_fault  <= 1'b0;
      r_uncorr <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op_a  <= in_a;
            r_op_b  <= in_b;
            r_state <= S_EVAL1;
          end
        end
        S_EVAL1: begin
          r_s1    <= add_s;
          r_state <= S_EVAL2;
        end
        S_EVAL2: begin
          r_s2 <= add_s;
          if ((add_s == r_s1) && w_s1_ok) begin
            r_sum    <= r_s1;
            r_fault  <= 1'b0;
            r_uncorr <= 1'b0;
            r_state  <= S_DONE;
          end else if (RETRY_EN != 0) begin
            r_state <= S_EVAL3;
          end else begin
            r_sum    <= r_s1;
            r_fault  <= 1'b1;
            r_uncorr <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_EVAL3: begin
          // Vote directly on the live third sample; r_s3 keeps it for debug.
          r_s3    <= add_s;
          r_fault <= 1'b1;
          r_state <= S_DONE;
          if ((add_s == r_s1) && w_add_ok) begin
            r_sum    <= r_s1;
            r_uncorr <= 1'b0;
          end else if ((add_s == r_s2) && w_add_ok) begin
            r_sum    <= r_s2;
            r_uncorr <= 1'b0;
          end else begin
            r_sum    <= r_s1;
            r_uncorr <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Clear takes priority over an increment landing on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault_cnt  <= '0;
      r_uncorr_cnt <= '0;
    end else if (clr_cnt) begin
      r_fault_cnt  <= '0;
      r_uncorr_cnt <= '0;
    end else if (w_hs) begin
      if (r_fault && (r_fault_cnt != CNT_MAX)) begin
        r_fault_cnt <= r_fault_cnt + CNT_ONE;
      end
      if (r_uncorr && (r_uncorr_cnt != CNT_MAX)) begin
        r_uncorr_cnt <= r_uncorr_cnt + CNT_ONE;
      end
    end
  end

  // Second evaluation swaps the operands so a stuck adder port shows up.
  always_comb begin
    add_a = 4'd0;
    add_b = 4'd0;
    case (r_state)
      S_EVAL1, S_EVAL3: begin
        add_a = r_op_a;
        add_b = r_op_b;
      end
      S_EVAL2: begin
        add_a = r_op_b;
        add_b = r_op_a;
      end
      default: begin
        add_a = 4'd0;
        add_b = 4'd0;
      end
    endcase
  end

  assign in_ready      = (r_state == S_IDLE);
  assign out_valid     = (r_state == S_DONE);
  assign out_sum       = r_sum;
  assign out_fault     = r_fault;
  assign out_uncorr    = r_uncorr;
  assign fault_cnt     = r_fault_cnt;
  assign uncorr_cnt    = r_uncorr_cnt;
  assign o_dbg_state   = r_state;
  assign o_dbg_samples = {r_s3, r_s2, r_s1};

endmodule

// File: tb/tb_addr4u_tr_checker.sv
// Bench for addr4u_tr_checker: instance 0 uses defaults (retry on, 8-bit
// counters), instance 1 has retry off and 2-bit counters.
module tb_addr4u_tr_checker;

  logic        clk;
  logic        rst_n      [2];
  logic        in_valid   [2];
  logic        in_ready   [2];
  logic [3:0]  in_a       [2];
  logic [3:0]  in_b       [2];
  logic [3:0]  add_a      [2];
  logic [3:0]  add_b      [2];
  logic [4:0]  add_s      [2];
  logic        out_valid  [2];
  logic        out_ready  [2];
  logic [4:0]  out_sum    [2];
  logic        out_fault  [2];
  logic        out_uncorr [2];
  logic        clr_cnt    [2];
  logic [2:0]  dbg_state  [2];
  logic [14:0] dbg_samp   [2];
  logic [7:0]  fault_cnt0, uncorr_cnt0;
  logic [1:0]  fault_cnt1, uncorr_cnt1;
  logic [7:0]  fcnt       [2];
  logic [7:0]  ucnt       [2];

  // Adder model with per-instance fault injection.
  logic        ov_en  [2];
  logic [4:0]  ov_val [2];

  int          checks;
  int          errors;
  logic [6:0]  exp_q [$];
  int          exp_fc [2];
  int          exp_uc [2];
  int          cmax   [2];

  addr4u_tr_checker u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a(in_a[0]), .in_b(in_b[0]), .add_a(add_a[0]), .add_b(add_b[0]), .add_s(add_s[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_sum(out_sum[0]),
    .out_fault(out_fault[0]), .out_uncorr(out_uncorr[0]), .clr_cnt(clr_cnt[0]),
    .fault_cnt(fault_cnt0), .uncorr_cnt(uncorr_cnt0),
    .o_dbg_state(dbg_state[0]), .o_dbg_samples(dbg_samp[0])
  );

  addr4u_tr_checker #(.CNT_W(2), .RETRY_EN(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a(in_a[1]), .in_b(in_b[1]), .add_a(add_a[1]), .add_b(add_b[1]), .add_s(add_s[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_sum(out_sum[1]),
    .out_fault(out_fault[1]), .out_uncorr(out_uncorr[1]), .clr_cnt(clr_cnt[1]),
    .fault_cnt(fault_cnt1), .uncorr_cnt(uncorr_cnt1),
    .o_dbg_state(dbg_state[1]), .o_dbg_samples(dbg_samp[1])
  );

  assign add_s[0] = ov_en[0] ? ov_val[0] : ({1'b0, add_a[0]} + {1'b0, add_b[0]});
  assign add_s[1] = ov_en[1] ? ov_val[1] : ({1'b0, add_a[1]} + {1'b0, add_b[1]});
  assign fcnt[0]  = fault_cnt0;
  assign ucnt[0]  = uncorr_cnt0;
  assign fcnt[1]  = {6'd0, fault_cnt1};
  assign ucnt[1]  = {6'd0, uncorr_cnt1};

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_counters(input int d, input string tag);
    checks++;
    if (fcnt[d] !== 8'(exp_fc[d]) || ucnt[d] !== 8'(exp_uc[d])) begin
      errors++;
      $display("FAIL %s counters inst%0d: got fault=%0d uncorr=%0d, want fault=%0d uncorr=%0d",
               tag, d, fcnt[d], ucnt[d], exp_fc[d], exp_uc[d]);
    end
  endtask

  // Driver + scoreboard for one transaction. oen/oval give the injected adder
  // output for EVAL1..3 (oval = {stage3, stage2, stage1}).
  task automatic run_txn(input int d, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] oen, input logic [14:0] oval,
                         input logic [4:0] esum, input logic ef, input logic eu,
                         input int elat, input int hold, input bit clr_hs);
    int          lat;
    logic [3:0]  ea;
    logic [3:0]  eb;
    logic [6:0]  exp;
    logic [6:0]  got;
    @(negedge clk);
    checks++;
    if (in_ready[d] !== 1'b1) begin
      errors++;
      $display("FAIL idle_ready inst%0d: got %b want 1", d, in_ready[d]);
    end
    in_valid[d] = 1'b1;
    in_a[d]     = a;
    in_b[d]     = b;
    exp_q.push_back({esum, ef, eu});
    @(posedge clk);
    @(negedge clk);
    in_valid[d] = 1'b0;
    in_a[d]     = 4'($urandom_range(0, 15));
    in_b[d]     = 4'($urandom_range(0, 15));
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      if (out_valid[d] === 1'b1) begin
        lat = c;
        break;
      end
      if (c <= 3) begin
        ea = (c == 2) ? b : a;
        eb = (c == 2) ? a : b;
        checks++;
        if (add_a[d] !== ea || add_b[d] !== eb) begin
          errors++;
          $display("FAIL eval%0d_ports inst%0d: got a=%0d b=%0d want a=%0d b=%0d",
                   c, d, add_a[d], add_b[d], ea, eb);
        end
        ov_en[d]  = oen[c-1];
        ov_val[d] = oval[(c-1)*5 +: 5];
      end
      @(negedge clk);
    end
    ov_en[d] = 1'b0;
    checks++;
    if (lat != elat) begin
      errors++;
      $display("FAIL latency inst%0d: got %0d want %0d (0 = timeout)", d, lat, elat);
    end
    exp = exp_q.pop_front();
    if (lat != 0) begin
      got = {out_sum[d], out_fault[d], out_uncorr[d]};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL result inst%0d a=%0d b=%0d: got sum=%0d f=%b u=%b want sum=%0d f=%b u=%b",
                 d, a, b, got[6:2], got[1], got[0], exp[6:2], exp[1], exp[0]);
      end
      checks++;
      if (add_a[d] !== 4'd0 || add_b[d] !== 4'd0) begin
        errors++;
        $display("FAIL done_ports inst%0d: got a=%0d b=%0d want 0 0", d, add_a[d], add_b[d]);
      end
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        checks++;
        if (out_valid[d] !== 1'b1 || in_ready[d] !== 1'b0 ||
            {out_sum[d], out_fault[d], out_uncorr[d]} !== exp) begin
          errors++;
          $display("FAIL hold%0d inst%0d: got v=%b rdy=%b sum=%0d want v=1 rdy=0 sum=%0d",
                   h, d, out_valid[d], in_ready[d], out_sum[d], exp[6:2]);
        end
      end
      out_ready[d] = 1'b1;
      clr_cnt[d]   = clr_hs;
      if (clr_hs) begin
        exp_fc[d] = 0;
        exp_uc[d] = 0;
      end else begin
        if (ef && exp_fc[d] < cmax[d]) exp_fc[d]++;
        if (eu && exp_uc[d] < cmax[d]) exp_uc[d]++;
      end
      @(posedge clk);
      @(negedge clk);
      out_ready[d] = 1'b0;
      clr_cnt[d]   = 1'b0;
      checks++;
      if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1) begin
        errors++;
        $display("FAIL release inst%0d: got v=%b rdy=%b want v=0 rdy=1", d, out_valid[d], in_ready[d]);
      end
      check_counters(d, "post_hs");
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; in_valid[d] = 1'b1; in_a[d] = 4'd5; in_b[d] = 4'd6;
      out_ready[d] = 1'b0; clr_cnt[d] = 1'b0; ov_en[d] = 1'b0; ov_val[d] = 5'd0;
      exp_fc[d] = 0; exp_uc[d] = 0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (dbg_state[d] !== 3'd0 || in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 ||
          out_sum[d] !== 5'd0 || out_fault[d] !== 1'b0 || out_uncorr[d] !== 1'b0 ||
          dbg_samp[d] !== 15'd0) begin
        errors++;
        $display("FAIL reset_state inst%0d: got st=%0d rdy=%b v=%b sum=%0d samp=%h want st=0 rdy=1 v=0 sum=0 samp=0",
                 d, dbg_state[d], in_ready[d], out_valid[d], out_sum[d], dbg_samp[d]);
      end
      check_counters(d, "reset");
      in_valid[d] = 1'b0;
      rst_n[d]    = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic test_clean();
    run_txn(0, 4'd9, 4'd7, 3'b000, 15'd0, 5'd16, 1'b0, 1'b0, 3, 0, 1'b0);
    run_txn(0, 4'd15, 4'd15, 3'b000, 15'd0, 5'd30, 1'b0, 1'b0, 3, 0, 1'b0);
    run_txn(0, 4'd0, 4'd0, 3'b000, 15'd0, 5'd0, 1'b0, 1'b0, 3, 0, 1'b0);
    run_txn(1, 4'd12, 4'd1, 3'b000, 15'd0, 5'd13, 1'b0, 1'b0, 3, 0, 1'b0);
  endtask

  task automatic test_transient();
    run_txn(0, 4'd3, 4'd4, 3'b010, {5'd0, 5'd5, 5'd0}, 5'd7, 1'b1, 1'b0, 4, 0, 1'b0);
    // First sample corrupted; third sample sides with the swapped evaluation.
    run_txn(0, 4'd2, 4'd2, 3'b001, {5'd0, 5'd0, 5'd9}, 5'd4, 1'b1, 1'b0, 4, 0, 1'b0);
  endtask

  task automatic test_uncorr();
    run_txn(0, 4'd6, 4'd8, 3'b111, {5'd3, 5'd2, 5'd1}, 5'd1, 1'b1, 1'b1, 4, 0, 1'b0);
    checks++;
    if (dbg_samp[0] !== {5'd3, 5'd2, 5'd1}) begin
      errors++;
      $display("FAIL samples inst0: got %h want %h", dbg_samp[0], {5'd3, 5'd2, 5'd1});
    end
    run_txn(1, 4'd6, 4'd8, 3'b011, {5'd0, 5'd2, 5'd1}, 5'd1, 1'b1, 1'b1, 3, 0, 1'b0);
  endtask

  task automatic test_illegal();
    run_txn(0, 4'd15, 4'd15, 3'b111, {5'd30, 5'd31, 5'd31}, 5'd31, 1'b1, 1'b1, 4, 0, 1'b0);
    // Agreeing but illegal first two samples still force a retry and a fault.
    run_txn(0, 4'd7, 4'd7, 3'b011, {5'd0, 5'd31, 5'd31}, 5'd31, 1'b1, 1'b1, 4, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_txn(0, 4'd10, 4'd5, 3'b000, 15'd0, 5'd15, 1'b0, 1'b0, 3, 10, 1'b0);
    run_txn(0, 4'd3, 4'd4, 3'b010, {5'd0, 5'd5, 5'd0}, 5'd7, 1'b1, 1'b0, 4, 4, 1'b0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_valid[0] = 1'b1; in_a[0] = 4'd5; in_b[0] = 4'd6;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (dbg_state[0] !== 3'd2) begin
      errors++;
      $display("FAIL pre_reset_state inst0: got %0d want 2", dbg_state[0]);
    end
    rst_n[0]  = 1'b0;
    exp_fc[0] = 0;
    exp_uc[0] = 0;
    @(negedge clk);
    checks++;
    if (dbg_state[0] !== 3'd0 || out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset inst0: got st=%0d v=%b rdy=%b want st=0 v=0 rdy=1",
               dbg_state[0], out_valid[0], in_ready[0]);
    end
    check_counters(0, "mid_reset");
    rst_n[0] = 1'b1;
    @(negedge clk);
    run_txn(0, 4'd1, 4'd14, 3'b000, 15'd0, 5'd15, 1'b0, 1'b0, 3, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [3:0] a;
    logic [3:0] b;
    for (int i = 0; i < 6; i++) begin
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      run_txn(0, a, b, 3'b000, 15'd0, 5'(a) + 5'(b), 1'b0, 1'b0, 3, $urandom_range(0, 2), 1'b0);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      run_txn(1, 4'd4, 4'd4, 3'b011, {5'd0, 5'd9, 5'd8}, 5'd8, 1'b1, 1'b1, 3, 0, 1'b0);
    end
    checks++;
    if (fault_cnt1 !== 2'd3 || uncorr_cnt1 !== 2'd3) begin
      errors++;
      $display("FAIL saturate inst1: got fault=%0d uncorr=%0d want 3 3", fault_cnt1, uncorr_cnt1);
    end
    run_txn(1, 4'd4, 4'd4, 3'b011, {5'd0, 5'd9, 5'd8}, 5'd8, 1'b1, 1'b1, 3, 0, 1'b1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cmax[0] = 255;
    cmax[1] = 3;
    test_reset();
    test_clean();
    test_transient();
    test_uncorr();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
